// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package mux4_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam int NUM_REQ = 4;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] PTR_RESET = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/data bundle between the requesters (master) and the arbiter (slave).
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       gnt;
  logic             s1;
  logic             s0;
  logic             busy;
  logic [WIDTH-1:0] out;

  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, s1, s0, busy, out
  );

  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, s1, s0, busy, out
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping back to ptr last.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  // Walk from farthest to nearest so the closest candidate is written last and wins.
  always_comb begin
    logic [IDX_W-1:0] w_cand;
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_cand  = i_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = i_ptr + IDX_W'(k);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux; define ARB_TIMEOUT_EN to cap each grant at HOLD_MAX cycles.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input logic clk,
  input logic rst,
  mux4_rr_arbiter_if.slave bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be within 2..255");
  end

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]     r_sel;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_pickReq;
  logic                 w_found;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_ownerReq;
  logic                 w_forced;
  logic [WIDTH-1:0]     w_out;

  // The current owner is masked so a handoff always lands on someone else.
  assign w_pickReq  = bus.req & ~r_gnt;
  assign w_ownerReq = |(bus.req & r_gnt);

  rr_pick u_pick (
    .i_req   (w_pickReq),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] r_holdCnt;

  assign w_forced = (r_holdCnt == HOLD_LAST) && w_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_holdCnt <= 8'd0;
    end else if (r_state == IDLE || !w_ownerReq || w_forced) begin
      r_holdCnt <= 8'd0;
    end else if (r_holdCnt != HOLD_LAST) begin
      r_holdCnt <= r_holdCnt + 8'd1;
    end
  end
`else
  assign w_forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= PTR_RESET;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_gnt   <= idx_to_onehot(w_idx);
            r_sel   <= w_idx;
            r_ptr   <= w_idx;
            r_busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (w_ownerReq && !w_forced) begin
            r_state <= GRANT;
          end else if (w_found) begin
            r_gnt   <= idx_to_onehot(w_idx);
            r_sel   <= w_idx;
            r_ptr   <= w_idx;
          end else begin
            // Select lines deliberately keep the last owner's index.
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_out = '0;
    if (r_busy) begin
      case (r_sel)
        2'd0:    w_out = bus.d0;
        2'd1:    w_out = bus.d1;
        2'd2:    w_out = bus.d2;
        default: w_out = bus.d3;
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.s1   = r_sel[1];
  assign bus.s0   = r_sel[0];
  assign bus.busy = r_busy;
  assign bus.out  = w_out;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized bench for mux4_rr_arbiter against an integer-level round-robin model; honours ARB_TIMEOUT_EN.
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 8;
`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_MAX = 4;
`else
  localparam int HOLD_MAX = 16;
`endif

  logic clk = 1'b0;
  logic rst;

  mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux4_rr_arbiter #(
    .WIDTH    (WIDTH),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: owner is -1 when nobody holds the grant; last is the round-robin pointer.
  int mOwner;
  int mLast;
  int mSel;
  int mHeld;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int firstAfter(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic [3:0] r, input logic rs);
    int nxt;
    bit keep;
    if (rs) begin
      mOwner = -1;
      mLast  = 3;
      mSel   = 0;
      mHeld  = 0;
    end else if (mOwner < 0) begin
      nxt = firstAfter(r, mLast);
      if (nxt >= 0) begin
        mOwner = nxt;
        mLast  = nxt;
        mSel   = nxt;
        mHeld  = 1;
      end
    end else begin
      logic [3:0] others;
      others = r;
      others[mOwner] = 1'b0;
      nxt  = firstAfter(others, mOwner);
      keep = r[mOwner];
`ifdef ARB_TIMEOUT_EN
      if (keep && mHeld >= HOLD_MAX && nxt >= 0) keep = 1'b0;
`endif
      if (keep) begin
        mHeld++;
      end else if (nxt >= 0) begin
        mOwner = nxt;
        mLast  = nxt;
        mSel   = nxt;
        mHeld  = 1;
      end else begin
        mOwner = -1;
        mHeld  = 0;
      end
    end
  endtask

  task automatic compareAll();
    logic [3:0] expGnt;
    logic [WIDTH-1:0] expOut;
    logic [WIDTH-1:0] dArr [4];
    dArr[0] = bus.d0;
    dArr[1] = bus.d1;
    dArr[2] = bus.d2;
    dArr[3] = bus.d3;
    expGnt = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    expOut = (mOwner < 0) ? '0 : dArr[mSel];
    checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
    checkOutput("sel", 32'({bus.s1, bus.s0}), 32'(mSel));
    checkOutput("busy", 32'(bus.busy), 32'(mOwner >= 0));
    checkOutput("out", 32'(bus.out), 32'(expOut));
    checkOutput("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    checkOutput("busyIsOrGnt", 32'(bus.busy), 32'(|bus.gnt));
    if (bus.busy) checkOutput("gntMatchesSel", 32'(bus.gnt), 32'(4'b0001 << {bus.s1, bus.s0}));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
    bus.d0  = WIDTH'($urandom);
    bus.d1  = WIDTH'($urandom);
    bus.d2  = WIDTH'($urandom);
    bus.d3  = WIDTH'($urandom);
    @(posedge clk);
    modelStep(r, rs);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    logic [3:0] rnd;
    bus.req = 4'b0000;
    bus.d0  = '0;
    bus.d1  = '0;
    bus.d2  = '0;
    bus.d3  = '0;
    rst     = 1'b1;
    mOwner  = -1;
    mLast   = 3;
    mSel    = 0;
    mHeld   = 0;

    $display("[TB] reset with all requesters active");
    repeat (3) applyStimulus(4'b1111, 1'b1);
    checkOutput("resetGnt", 32'(bus.gnt), 32'd0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("firstGnt", 32'(bus.gnt), 32'b0001);
    bus.d0 = 8'hA5;
    #1;
    checkOutput("outA5", 32'(bus.out), 32'hA5);

    $display("[TB] direct handoffs around the ring");
    applyStimulus(4'b1110, 1'b0);
    checkOutput("handoff1", 32'(bus.gnt), 32'b0010);
    applyStimulus(4'b1100, 1'b0);
    checkOutput("handoff2", 32'(bus.gnt), 32'b0100);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("handoff3", 32'(bus.gnt), 32'b1000);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("handoffWrap", 32'(bus.gnt), 32'b0001);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] single requester then release");
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single2", 32'(bus.gnt), 32'b0100);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("releaseBusy", 32'(bus.busy), 32'd0);
    checkOutput("releaseSel", 32'({bus.s1, bus.s0}), 32'd2);
    checkOutput("releaseOut", 32'(bus.out), 32'd0);

    $display("[TB] reset pulse mid-grant");
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("midResetGnt", 32'(bus.gnt), 32'd0);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("postResetGnt", 32'(bus.gnt), 32'b0010);

`ifdef ARB_TIMEOUT_EN
    $display("[TB] hold timeout with two requesters");
    repeat (16) applyStimulus(4'b0011, 1'b0);
    $display("[TB] hold timeout with a lone requester");
    repeat (12) applyStimulus(4'b0001, 1'b0);
    checkOutput("loneHolds", 32'(bus.gnt), 32'b0001);
`else
    $display("[TB] long hold without timeout");
    repeat (24) applyStimulus(4'b0011, 1'b0);
    checkOutput("longHold", 32'(bus.gnt), 32'b0010);
`endif

    $display("[TB] randomized traffic");
    rnd = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) != 0) rnd = 4'($urandom);
      applyStimulus(rnd, $urandom_range(0, 49) == 0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data bit width per input.
REQ-002 Parameter: HOLD_MAX, 16, max cycles per grant when timeout compiled in (legal 2..255).
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  4  per-requester request, level; bit n = requester n.
REQ-006 Port: d0, d1, d2, d3  input  WIDTH each  requester data.
REQ-007 Port: gnt  output  4  one-hot grant, registered.
REQ-008 Port: s1, s0  output  1 each  registered select for shared 4:1 mux ({s1,s0} = owner index).
REQ-009 Port: busy  output  1  high while any grant held.
REQ-010 Port: out  output  WIDTH  selected data.
REQ-011 One clock; reset synchronous, active-high, on ports clk and rst.

Function
REQ-012 Two states SHALL exist: IDLE (no owner), GRANT (owner held).
REQ-013 Round-robin pointer ptr (2 bits) = last owner; search order ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 IDLE with req != 0: next edge -> GRANT, gnt = first requester in search order, {s1,s0} = its index, ptr = index; latency one cycle.
REQ-015 IDLE with req == 0: stay IDLE, gnt=0, busy=0.
REQ-016 GRANT, req[owner]=1: hold owner, outputs unchanged.
REQ-017 GRANT, req[owner]=0, others pending: direct handoff next edge to next in search order (pointer already = old owner); no idle cycle.
REQ-018 GRANT, req[owner]=0, none pending: -> IDLE, gnt=0, busy=0; {s1,s0} retain last value.
REQ-019 gnt SHALL be one-hot or zero every cycle; busy = |gnt.
REQ-020 out = data input indexed by {s1,s0} when busy=1, else all zeros; combinational from registered selects.
REQ-021 Requester dropping req for one cycle loses grant; re-request competes normally.

Reset
REQ-022 rst=1 at an edge: state IDLE, gnt=0, s1=s0=0, busy=0, ptr=3 (requester 0 highest priority first), hold counter 0; overrides all other events, including mid-grant.
REQ-023 First grant SHALL be evaluated on the edge after rst deasserts.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: hold counter (8 bits) clears on each new grant, increments per GRANT cycle; at count HOLD_MAX-1 with another requester pending, forced handoff next edge as REQ-017 even if req[owner]=1; with none pending, owner keeps grant, counter saturates.
REQ-025 Macro undefined: no counter; grant held indefinitely while req[owner]=1; HOLD_MAX ignored.

Structure
REQ-026 Package mux4_arb_pkg: state enum (IDLE, GRANT), NUM_REQ=4, IDX_W=2, PTR_RESET=2'd3.
REQ-027 Sub-module rr_pick: combinational; inputs req[3:0], ptr[1:0]; outputs found, idx[1:0]; per REQ-013.
REQ-028 Total RTL 120-400 lines.

Verification
REQ-029 rst 3 cycles, req=4'b1111 held -> gnt=0001, {s1,s0}=00 one cycle after rst drop; d0=8'hA5 -> out=8'hA5.
REQ-030 Owner 0 drops req, req=4'b1110 -> next edge gnt=0010, no cycle with busy=0; then successive drops -> 0100, 1000, then 0001 if req[0] set.
REQ-031 req=4'b0100 then 0 -> gnt=0100 one edge later; after drop, IDLE, busy=0, out=0, {s1,s0}=10 retained.
REQ-032 ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held -> gnt alternates 0001/0010 every 4 cycles; req=4'b0001 only -> 0001 held, no release.
REQ-033 Grant to 2 active, rst pulsed one cycle mid-grant -> next edge gnt=0, ptr=3; with req=4'b0110 held, first grant after rst = 0010.
REQ-034 Assertions every cycle: $onehot0(gnt); busy == |gnt; gnt index == {s1,s0} when busy.
